ifetch_bus_arbiter: RTL and testbench
=====================================

// Module: ifetch_bus_arbiter
// PURPOSE
// - Shares the single 64-bit instruction-memory port between two requesters: port 0 is the fetch
//   prefetch buffer, port 1 is a secondary reader (LSU loads from instruction memory, debug).
// - Sits between the prefetch buffer and the instruction memory / icache.
// - Holds the chosen requester until grant, limits outstanding transactions, and returns each
//   rvalid/rdata/err to the port that issued it, in order.
// PARAMETERS
// - MaxOutstanding  2   granted-but-unreturned transactions allowed on the bus (1..4)
// - StarveLimit     4   consecutive port-1 losses before port 1 is forced (IFETCH_ARB_FAIR_EN only)
// PORTS
// - clk_i          in   1   clock
// - rst_ni         in   1   asynchronous active-low reset
// - req0_i/req1_i  in   1   request per port; held stable until its grant
// - addr0_i/addr1_i in  32  request address per port
// - gnt0_o/gnt1_o  out  1   grant per port (combinational from instr_gnt_i)
// - rvalid0_o/rvalid1_o out 1 return valid per port
// - rdata_o        out  64  return data, shared by both ports
// - err_o          out  1   return error, shared by both ports
// - instr_req_o    out  1   downstream request
// - instr_addr_o   out  32  downstream address (passed through unmodified)
// - instr_gnt_i    in   1   downstream grant
// - instr_rvalid_i in   1   downstream return valid
// - instr_rdata_i  in   64  downstream return data
// - instr_err_i    in   1   downstream return error
// - busy_o         out  1   |outstanding or instr_req_o
// BEHAVIOUR
// - Reset: all outputs 0; lock cleared; owner FIFO empty; starve counter 0.
// - Issue gate: instr_req_o = sel_req & (cnt < MaxOutstanding). A same-cycle rvalid does not
//   free a slot for issue.
// - Select: when unlocked, port 0 wins if req0_i is high, otherwise port 1. instr_addr_o follows
//   the selected port.
// - Lock: instr_req_o high and instr_gnt_i low sets lock_q and latches lock_owner_q. While locked,
//   the latched port stays selected whatever the other request does. The lock clears on grant.
//   If the locked port drops its request, the lock clears; this is a protocol violation and is
//   covered by an assertion.
// - Grant: gnt<sel>_o = instr_req_o & instr_gnt_i. Each grant pushes the owner id into the owner
//   FIFO.
// - Return: rvalid<head>_o = instr_rvalid_i. rdata_o and err_o pass through combinationally with
//   zero latency. Each rvalid pops the FIFO head.
// - rvalid is legal no earlier than the cycle after the matching grant. rvalid with an empty FIFO
//   is dropped: no port rvalid, and an assertion fires.
// - Grant and rvalid in the same cycle: push and pop together; count is unchanged.
// - Pointers: FIFO pointers wrap modulo MaxOutstanding. The count is a clog2(MaxOutstanding+1)-bit
//   saturating-free counter, and overflow is unreachable by construction.
// - Port 0 branches: no flush is done here. The prefetch buffer discards stale returns itself, so
//   the arbiter always returns every beat to its owner.
// - Reset mid-transaction: all state clears immediately. Late rvalids after reset are dropped as
//   empty-FIFO returns.
// CONFIGURATION
// - IFETCH_ARB_FAIR_EN defined: a 3-bit starve counter increments on each cycle in which req1_i
//   is high, port 1 is unlocked, and port 0 is granted. It clears on a port-1 grant.
//   - When the counter reaches StarveLimit and the arbiter is unlocked, port 1 is selected over
//     port 0.
// - IFETCH_ARB_FAIR_EN not defined: strict port-0 priority; no counter is instantiated.
// STRUCTURE
// - super_pkg gains:
//   - typedef enum logic {IFARB_FETCH=1'b0, IFARB_AUX=1'b1} ifarb_owner_e
//   - localparam int unsigned IFARB_MAX_OUTSTANDING = 2
// - Sub-module ifetch_arb_owner_fifo holds the owner id FIFO:
//   - inputs: push, id_in, pop
//   - outputs: head_id, cnt, empty, full
// - Select, lock and starve logic stay in the top module.
// TESTING
// - req0 @0x100, gnt same cycle, rvalid next cycle with rdata 0xDEAD_BEEF_0123_4567
//   -> gnt0_o=1, then rvalid0_o=1 with that rdata, rvalid1_o=0.
// - req0 and req1 together, gnt held low 3 cycles -> instr_addr_o=addr0 every cycle.
//   - Drop req0 while locked: assertion fires.
//   - Raise req1 mid-wait, then grant: gnt0_o=1, next cycle addr1 is issued.
// - Grants to port 1 then port 0 back-to-back, rvalids delayed 2 cycles
//   -> returns arrive as rvalid1_o then rvalid0_o; err on the second beat reaches port 0 only.
// - 2 outstanding, req0 high -> instr_req_o=0 until an rvalid. Grant and rvalid in the same
//   cycle -> cnt stays 2.
// - IFETCH_ARB_FAIR_EN, req0 and req1 held high, gnt every cycle -> port 1 is granted on every
//   5th grant. Without the macro, port 1 is never granted.
// - rst_ni low with 2 outstanding, then 2 stray rvalids after release -> no port rvalid, busy_o=0.

Source files
------------

// File: rtl/ifetch_bus_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch bus arbiter.
package ifetch_bus_arbiter_pkg;

   // Which requester owns a bus transaction
   typedef enum logic {
      IFARB_FETCH = 1'b0,
      IFARB_AUX   = 1'b1
   } ifarb_owner_e;

   // Hold-until-grant lock state
   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } ifarb_lock_e;

   localparam int unsigned IFARB_MAX_OUTSTANDING = 2;
   localparam int unsigned IFARB_STARVE_LIMIT    = 4;
   localparam int unsigned IFARB_STARVE_W        = 3;

   // Pointer width for a FIFO of the given depth (at least one bit)
   function automatic int unsigned ifarb_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ifetch_arb_owner_fifo.sv
// Owner-id FIFO: remembers which port issued each outstanding transaction.
module ifetch_arb_owner_fifo
   import ifetch_bus_arbiter_pkg::*;
#(
   parameter  int unsigned Depth = IFARB_MAX_OUTSTANDING,
   localparam int unsigned CntW  = $clog2(Depth + 1),
   localparam int unsigned PtrW  = ifarb_ptr_w(Depth)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  ifarb_owner_e    id_in,
   input  logic            pop,
   output ifarb_owner_e    head_id,
   output logic [CntW-1:0] cnt,
   output logic            empty,
   output logic            full
);

   ifarb_owner_e    mem_q [Depth];
   logic [PtrW-1:0] wr_q;
   logic [PtrW-1:0] rd_q;
   logic [CntW-1:0] cnt_q;

   // Pointer advance, wrapping modulo Depth
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Storage and pointers; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= IFARB_FETCH;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= id_in;
            wr_q        <= ptr_inc(wr_q);
         end
         if (pop) begin
            rd_q <= ptr_inc(rd_q);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   assign head_id = mem_q[rd_q];
   assign cnt     = cnt_q;
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/ifetch_bus_arbiter.sv
// Two-port arbiter for the 64-bit instruction-memory port: port 0 is the
// prefetch buffer, port 1 the secondary reader. Holds the selected port
// until granted, bounds outstanding transactions and routes every return
// to its issuing port in order.
// Optional: IFETCH_ARB_FAIR_EN adds a starvation counter that forces port 1
// after StarveLimit consecutive losses to port 0.
module ifetch_bus_arbiter
   import ifetch_bus_arbiter_pkg::*;
#(
   parameter int unsigned MaxOutstanding = IFARB_MAX_OUTSTANDING,
   parameter int unsigned StarveLimit    = IFARB_STARVE_LIMIT,
   parameter bit          AssertEn       = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req0_i,
   input  logic [31:0] addr0_i,
   input  logic        req1_i,
   input  logic [31:0] addr1_i,
   output logic        gnt0_o,
   output logic        gnt1_o,
   output logic        rvalid0_o,
   output logic        rvalid1_o,
   output logic [63:0] rdata_o,
   output logic        err_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [63:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        busy_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   ifarb_lock_e     lock_q, lock_d;
   ifarb_owner_e    lock_owner_q, lock_owner_d;
   ifarb_owner_e    sel_c;
   ifarb_owner_e    head_id;
   logic            sel_req_c;
   logic            gnt_c;
   logic            pop_c;
   logic            force_aux_c;
   logic [CntW-1:0] cnt;
   logic            empty;
   logic            full;
   logic            lock_drop_c;
   logic            stray_rvalid_c;

`ifdef IFETCH_ARB_FAIR_EN
   logic [IFARB_STARVE_W-1:0] starve_q;

   // Count cycles port 1 loses to a port-0 grant; a port-1 grant clears it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q <= '0;
      end else if (gnt1_o) begin
         starve_q <= '0;
      end else if (gnt0_o && req1_i && !(lock_q == LOCK_HELD && lock_owner_q == IFARB_AUX)
                   && (starve_q != '1)) begin
         starve_q <= starve_q + IFARB_STARVE_W'(1);
      end
   end

   assign force_aux_c = req1_i & (starve_q >= IFARB_STARVE_W'(StarveLimit));
`else
   logic starve_limit_unused;
   assign starve_limit_unused = ^StarveLimit;
   assign force_aux_c         = 1'b0;
`endif

   // Select: lock owner, else starved port 1, else port 0 priority
   always_comb begin
      sel_c = IFARB_AUX;
      if (lock_q == LOCK_HELD) begin
         sel_c = lock_owner_q;
      end else if (force_aux_c) begin
         sel_c = IFARB_AUX;
      end else if (req0_i) begin
         sel_c = IFARB_FETCH;
      end
   end

   assign sel_req_c    = (sel_c == IFARB_FETCH) ? req0_i : req1_i;
   assign instr_req_o  = sel_req_c & ~full;
   assign instr_addr_o = (sel_c == IFARB_FETCH) ? addr0_i : addr1_i;
   assign gnt_c        = instr_req_o & instr_gnt_i;
   assign gnt0_o       = gnt_c & (sel_c == IFARB_FETCH);
   assign gnt1_o       = gnt_c & (sel_c == IFARB_AUX);

   // Returns go to the FIFO head; returns with nothing outstanding are dropped
   assign pop_c     = instr_rvalid_i & ~empty;
   assign rvalid0_o = pop_c & (head_id == IFARB_FETCH);
   assign rvalid1_o = pop_c & (head_id == IFARB_AUX);
   assign rdata_o   = instr_rdata_i;
   assign err_o     = instr_err_i;
   assign busy_o    = (cnt != '0) | instr_req_o;

   ifetch_arb_owner_fifo #(
      .Depth (MaxOutstanding)
   ) u_owner_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .push    (gnt_c),
      .id_in   (sel_c),
      .pop     (pop_c),
      .head_id (head_id),
      .cnt     (cnt),
      .empty   (empty),
      .full    (full)
   );

   // Lock state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q       <= LOCK_IDLE;
         lock_owner_q <= IFARB_FETCH;
      end else begin
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   // Lock next state: set on an ungranted request, clear on grant or request drop
   always_comb begin
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
      case (lock_q)
         LOCK_IDLE: begin
            if (instr_req_o && !instr_gnt_i) begin
               lock_d       = LOCK_HELD;
               lock_owner_d = sel_c;
            end
         end
         LOCK_HELD: begin
            if (!sel_req_c || gnt_c) begin
               lock_d = LOCK_IDLE;
            end
         end
      endcase
   end

   assign lock_drop_c    = (lock_q == LOCK_HELD) & ~sel_req_c;
   assign stray_rvalid_c = instr_rvalid_i & empty;

   if (AssertEn) begin : g_assert
      // A locked requester must hold its request until granted
      a_lock_hold : assert property (@(posedge clk_i) disable iff (!rst_ni) !lock_drop_c)
         else $error("ifetch_bus_arbiter: locked requester dropped its request");
      // Every return must match an outstanding grant
      a_no_stray : assert property (@(posedge clk_i) disable iff (!rst_ni) !stray_rvalid_c)
         else $error("ifetch_bus_arbiter: rvalid with no outstanding transaction");
   end

endmodule

// File: tb/tb_ifetch_bus_arbiter.sv
// Bench for ifetch_bus_arbiter: table of per-cycle vectors plus hand-written
// lock-drop, reset and fairness sequences; return routing is checked
// against an owner scoreboard. Fairness expectations follow IFETCH_ARB_FAIR_EN.
module tb_ifetch_bus_arbiter;
   import ifetch_bus_arbiter_pkg::*;

   localparam logic [31:0] A0 = 32'h0000_0100;
   localparam logic [31:0] A1 = 32'h0000_0200;

   logic        clk_i;
   logic        rst_ni;
   logic        req0_i, req1_i;
   logic [31:0] addr0_i, addr1_i;
   logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
   logic [63:0] rdata_o;
   logic        err_o;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i, instr_rvalid_i;
   logic [63:0] instr_rdata_i;
   logic        instr_err_i;
   logic        busy_o;

   typedef struct {
      logic        r0, r1, g, rv;
      logic [63:0] rd;
      logic        er;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_g0, e_g1, e_busy;
   } vec_t;

   vec_t         tbl[$];
   ifarb_owner_e sb[$];
   int           checks = 0;
   int           errors = 0;
   int           vidx   = 0;
   string        phase  = "init";

   ifetch_bus_arbiter #(.AssertEn(1'b0)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req0_i         (req0_i),
      .addr0_i        (addr0_i),
      .req1_i         (req1_i),
      .addr1_i        (addr1_i),
      .gnt0_o         (gnt0_o),
      .gnt1_o         (gnt1_o),
      .rvalid0_o      (rvalid0_o),
      .rvalid1_o      (rvalid1_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .busy_o         (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%s #%0d]: got %h want %h", nm, phase, vidx, act, exp);
      end
   endtask

   function automatic vec_t mk(input int r0, input int r1, input int g, input int rv,
                               input logic [63:0] rd, input int er, input int e_req,
                               input logic [31:0] e_addr, input int e_g0, input int e_g1,
                               input int e_busy);
      vec_t v;
      v.r0 = (r0 != 0);  v.r1 = (r1 != 0);  v.g = (g != 0);  v.rv = (rv != 0);
      v.rd = rd;         v.er = (er != 0);  v.e_req = (e_req != 0);
      v.e_addr = e_addr; v.e_g0 = (e_g0 != 0); v.e_g1 = (e_g1 != 0);
      v.e_busy = (e_busy != 0);
      return v;
   endfunction

   // Drive one cycle on the falling edge, check just after, update scoreboard
   task automatic apply(input vec_t v);
      ifarb_owner_e own;
      @(negedge clk_i);
      req0_i         = v.r0;
      req1_i         = v.r1;
      addr0_i        = A0;
      addr1_i        = A1;
      instr_gnt_i    = v.g;
      instr_rvalid_i = v.rv;
      instr_rdata_i  = v.rd;
      instr_err_i    = v.er;
      #1;
      chk("instr_req", 64'(instr_req_o), 64'(v.e_req));
      chk("instr_addr", 64'(instr_addr_o), 64'(v.e_addr));
      chk("gnt0", 64'(gnt0_o), 64'(v.e_g0));
      chk("gnt1", 64'(gnt1_o), 64'(v.e_g1));
      chk("busy", 64'(busy_o), 64'(v.e_busy));
      chk("rdata", rdata_o, v.rd);
      chk("err", 64'(err_o), 64'(v.er));
      if (v.rv && sb.size() > 0) begin
         own = sb.pop_front();
         chk("rvalid0", 64'(rvalid0_o), 64'(own == IFARB_FETCH));
         chk("rvalid1", 64'(rvalid1_o), 64'(own == IFARB_AUX));
      end else begin
         chk("rvalid0", 64'(rvalid0_o), 64'd0);
         chk("rvalid1", 64'(rvalid1_o), 64'd0);
      end
      if (v.e_g0) sb.push_back(IFARB_FETCH);
      if (v.e_g1) sb.push_back(IFARB_AUX);
      vidx++;
   endtask

   initial begin
      //        r0 r1 g  rv rdata                   er req addr e0 e1 busy
      tbl.push_back(mk(0, 0, 0, 0, 64'h0,                 0, 0, A1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 64'h0,                 0, 1, A0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 0, A1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 64'h0,                 0, 0, A1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 64'h0,                 0, 1, A0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 64'h0,                 0, 1, A0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 64'h0,                 0, 1, A0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 64'h0,                 0, 1, A0, 1, 0, 1));
      tbl.push_back(mk(0, 1, 1, 0, 64'h0,                 0, 1, A1, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 64'h1111,              0, 0, A1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 64'h2222,              0, 0, A1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 64'h0,                 0, 1, A1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 64'h0,                 0, 1, A1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 64'h0,                 0, 1, A1, 0, 1, 1));
      tbl.push_back(mk(1, 0, 1, 0, 64'h0,                 0, 1, A0, 1, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 64'h0,                 0, 0, A0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 1, 64'hAAAA,              0, 0, A0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 1, 64'hBBBB,              1, 1, A0, 1, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 64'h0,                 0, 1, A0, 1, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 64'h0,                 0, 0, A0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 1, 64'hCCCC,              0, 0, A0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 1, 64'hDDDD,              0, 1, A0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 64'hEEEE,              0, 0, A1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 64'h0,                 0, 0, A1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 64'hFFFF,              1, 0, A1, 0, 0, 0));

      rst_ni = 1'b0;
      req0_i = 1'b0;  req1_i = 1'b0;  addr0_i = '0;  addr1_i = '0;
      instr_gnt_i = 1'b0;  instr_rvalid_i = 1'b0;  instr_rdata_i = '0;  instr_err_i = 1'b0;
      #1;
      phase = "reset";
      chk("instr_req", 64'(instr_req_o), 64'd0);
      chk("busy", 64'(busy_o), 64'd0);
      chk("gnt0", 64'(gnt0_o), 64'd0);
      chk("gnt1", 64'(gnt1_o), 64'd0);
      chk("rvalid0", 64'(rvalid0_o), 64'd0);
      chk("rvalid1", 64'(rvalid1_o), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      phase = "table";
      vidx  = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // Locked port drops its request: flagged, then lock clears
      phase = "lock_drop";
      vidx  = 0;
      apply(mk(1, 0, 0, 0, 64'h0, 0, 1, A0, 0, 0, 1));
      apply(mk(0, 1, 0, 0, 64'h0, 0, 0, A0, 0, 0, 0));
      chk("lock_drop_flag", 64'(dut.lock_drop_c), 64'd1);
      apply(mk(0, 1, 0, 0, 64'h0, 0, 1, A1, 0, 0, 1));
      apply(mk(0, 1, 1, 0, 64'h0, 0, 1, A1, 0, 1, 1));
      apply(mk(0, 0, 0, 1, 64'h7777, 1, 0, A1, 0, 0, 1));

      // Reset with two outstanding, then stray returns are dropped
      phase = "rst_mid";
      vidx  = 0;
      apply(mk(1, 0, 1, 0, 64'h0, 0, 1, A0, 1, 0, 1));
      apply(mk(1, 0, 1, 0, 64'h0, 0, 1, A0, 1, 0, 1));
      @(negedge clk_i);
      req0_i = 1'b0;  instr_gnt_i = 1'b0;  rst_ni = 1'b0;
      #1;
      chk("busy_in_rst", 64'(busy_o), 64'd0);
      chk("req_in_rst", 64'(instr_req_o), 64'd0);
      sb.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply(mk(0, 0, 0, 1, 64'h5555, 0, 0, A1, 0, 0, 0));
      chk("stray_flag", 64'(dut.stray_rvalid_c), 64'd1);
      apply(mk(0, 0, 0, 1, 64'h6666, 1, 0, A1, 0, 0, 0));

      // Both ports requesting, grant every cycle, return one cycle later
      phase = "fair";
      vidx  = 0;
      for (int k = 0; k < 15; k++) begin
         logic aux;
`ifdef IFETCH_ARB_FAIR_EN
         aux = ((k % 5) == 4);
`else
         aux = 1'b0;
`endif
         apply(mk(1, 1, 1, int'(k > 0), 64'(k), 0, 1, aux ? A1 : A0,
                  int'(!aux), int'(aux), 1));
      end
      apply(mk(0, 0, 0, 1, 64'hF00D, 0, 0, A1, 0, 0, 1));
      apply(mk(0, 0, 0, 0, 64'h0, 0, 0, A1, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
